// File: rtl/sarray_drain.sv
// sarray_drain: buffers the array's bottom-edge rows and replays them as addressed store requests
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif
`ifndef SARRAY_STORE_WIDTH
`define SARRAY_STORE_WIDTH 512
`endif
module sarray_drain #(
  parameter int DEPTH = 8,
  parameter int CNT_W = `TMMA_CNT_WIDTH,
  parameter int DATA_W = `SARRAY_STORE_WIDTH,
  parameter int ADDR_W = 32,
  parameter int ROW_BYTES = `SARRAY_STORE_WIDTH / 8,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tile_start_i,
  input  logic [CNT_W-1:0]  tile_rows_i,
  input  logic [ADDR_W-1:0] tile_base_i,
  input  logic              bot_valid_i,
  input  logic [CNT_W-1:0]  bot_cnt_i,
  input  logic [DATA_W-1:0] bot_data_i,
  output logic              st_valid_o,
  input  logic              st_ready_i,
  output logic [ADDR_W-1:0] st_addr_o,
  output logic [DATA_W-1:0] st_data_o,
  output logic              post_storec_valid_o,
  output logic              afull_o,
  output logic              busy_o,
  output logic              ovf_err_o,
  output logic              seq_err_o,
  input  logic              err_clr_i
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
  state_t state;
  logic [CNT_W+DATA_W-1:0] mem [DEPTH];
  logic [CNT_W+DATA_W-1:0] head;
  logic [AW-1:0] wp, rp;
  logic [AW:0] occ;
  logic [CNT_W-1:0] rows_q, exp_q;
  logic [ADDR_W-1:0] base_q;
  logic push_req, pop, full, push, last, done, seq_set, ovf_set;
  always_comb begin
    push_req = bot_valid_i && state == ACTIVE;
    st_valid_o = occ != '0;
    pop = st_valid_o && st_ready_i;
    full = occ == (AW+1)'(DEPTH);
    push = push_req && (!full || pop);
    last = push_req && bot_cnt_i == rows_q;
    // the final row is always the tail, so the last pop of FLUSH is the tile's final store
    done = state == FLUSH && ((pop && occ == (AW+1)'(1)) || occ == '0);
    seq_set = bot_valid_i && (state != ACTIVE || bot_cnt_i != exp_q);
    ovf_set = push_req && full && !pop;
    head = mem[rp];
    st_data_o = st_valid_o ? head[DATA_W-1:0] : '0;
    st_addr_o = st_valid_o ? base_q + ADDR_W'(head[CNT_W+DATA_W-1:DATA_W]) * ADDR_W'(ROW_BYTES) : '0;
    afull_o = occ >= (AW+1)'(AFULL_LVL);
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk) if (push) mem[wp] <= {bot_cnt_i, bot_data_i};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rows_q <= '0;
      base_q <= '0;
      exp_q <= '0;
      wp <= '0;
      rp <= '0;
      occ <= '0;
      post_storec_valid_o <= 1'b0;
      ovf_err_o <= 1'b0;
      seq_err_o <= 1'b0;
    end else begin
      if (state == IDLE && tile_start_i) begin
        state <= ACTIVE;
        rows_q <= tile_rows_i;
        base_q <= tile_base_i;
        exp_q <= '0;
      end else if (last) state <= FLUSH;
      else if (done) state <= IDLE;
      if (push_req) exp_q <= exp_q + CNT_W'(1);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
      post_storec_valid_o <= done;
      ovf_err_o <= ovf_set || (ovf_err_o && !err_clr_i);
      seq_err_o <= seq_set || (seq_err_o && !err_clr_i);
    end
  end
endmodule
